// File: rtl/wb_sched_if.sv
// Writeback scheduler bus: pipeline result, memory return and register-file write port.
interface wb_sched_if;
  logic        alu_valid;
  logic [2:0]  alu_reg;
  logic [15:0] alu_data;
  logic        alu_stall;
  logic        mem_done;
  logic [2:0]  mem_reg;
  logic [15:0] mem_data;
  logic        wr_en;
  logic [2:0]  wr_reg;
  logic [15:0] wr_data;
  logic        err;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_done, mem_reg, mem_data,
    input  alu_stall, wr_en, wr_reg, wr_data, err
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_done, mem_reg, mem_data,
    output alu_stall, wr_en, wr_reg, wr_data, err
  );
endinterface

// File: rtl/wb_sched.sv
// Register-file write-port arbiter: memory return first, buffered ALU results next.
// Optional WB_SCHED_ERR_EN adds a pulse when a stalled ALU result is presented.
module wb_sched #(
  parameter int DEPTH = 2
) (
  input logic       clk,
  input logic       rst,
  wb_sched_if.slave bus
);
  localparam int PW = (DEPTH == 4) ? 2 : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] LAST_CNT = (PW+1)'(DEPTH - 1);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);

  typedef enum logic [1:0] {EMPTY, PART, FULL} state_t;

  state_t        state_q, state_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] head_q, tail_q;
  logic [2:0]    buf_reg  [DEPTH];
  logic [15:0]   buf_data [DEPTH];

  logic        accept, push, pop, direct;
  logic        wr_en_q;
  logic [2:0]  wr_reg_q;
  logic [15:0] wr_data_q;

  assign bus.alu_stall = (count_q == FULL_CNT);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_reg    = wr_reg_q;
  assign bus.wr_data   = wr_data_q;

  always_comb begin
    accept = bus.alu_valid & ~bus.alu_stall;
    pop    = ~bus.mem_done & (state_q != EMPTY);
    push   = accept & (bus.mem_done | (state_q != EMPTY));
    direct = accept & ~push;
  end

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (push && !pop) count_d = count_q + ONE_CNT;
    if (pop && !push) count_d = count_q - ONE_CNT;
    unique case (state_q)
      EMPTY: if (push && !pop) state_d = PART;
      PART: begin
        if (push && !pop && count_q == LAST_CNT)
          state_d = FULL;
        else if (pop && !push && count_q == ONE_CNT)
          state_d = EMPTY;
      end
      FULL: if (pop) state_d = PART;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_reg[tail_q]  <= bus.alu_reg;
      buf_data[tail_q] <= bus.alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= bus.mem_done | pop | direct;
      unique case (1'b1)
        bus.mem_done: begin
          wr_reg_q  <= bus.mem_reg;
          wr_data_q <= bus.mem_data;
        end
        pop: begin
          wr_reg_q  <= buf_reg[head_q];
          wr_data_q <= buf_data[head_q];
        end
        direct: begin
          wr_reg_q  <= bus.alu_reg;
          wr_data_q <= bus.alu_data;
        end
        default: ;
      endcase
    end
  end

`ifdef WB_SCHED_ERR_EN
  logic err_q;
  assign bus.err = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= bus.alu_valid & bus.alu_stall;
  end
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_wb_sched.sv
// Bench for wb_sched: directed scenarios then random traffic against a queue model.
module tb_wb_sched;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  wb_sched_if bus ();

  wb_sched #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [18:0] q[$];
  logic [2:0]  last_reg  = '0;
  logic [15:0] last_data = '0;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [2:0] ar, input logic [15:0] ad,
                      input logic m, input logic [2:0] mr,
                      input logic [15:0] md);
    logic        e_en, e_err, stall, acc;
    logic [18:0] head;
    rst = r;
    bus.alu_valid = v;
    bus.alu_reg   = ar;
    bus.alu_data  = ad;
    bus.mem_done  = m;
    bus.mem_reg   = mr;
    bus.mem_data  = md;
    stall = (q.size() == DEPTH);
    e_en  = 1'b0;
    e_err = 1'b0;
    if (r) begin
      q.delete();
      last_reg  = '0;
      last_data = '0;
    end else begin
`ifdef WB_SCHED_ERR_EN
      e_err = v && stall;
`endif
      acc = v && !stall;
      if (m) begin
        e_en = 1'b1;
        last_reg  = mr;
        last_data = md;
        if (acc) q.push_back({ar, ad});
      end else if (q.size() > 0) begin
        head = q.pop_front();
        e_en = 1'b1;
        last_reg  = head[18:16];
        last_data = head[15:0];
        if (acc) q.push_back({ar, ad});
      end else if (acc) begin
        e_en = 1'b1;
        last_reg  = ar;
        last_data = ad;
      end
    end
    @(posedge clk);
    #1;
    chk("wr_en", 16'(bus.wr_en), 16'(e_en));
    chk("wr_reg", 16'(bus.wr_reg), 16'(last_reg));
    chk("wr_data", bus.wr_data, last_data);
    chk("alu_stall", 16'(bus.alu_stall), 16'(q.size() == DEPTH));
    chk("err", 16'(bus.err), 16'(e_err));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  initial begin
    bus.alu_valid = 1'b0;
    bus.alu_reg   = '0;
    bus.alu_data  = '0;
    bus.mem_done  = 1'b0;
    bus.mem_reg   = '0;
    bus.mem_data  = '0;

    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    step(1'b1, 1'b1, 3'd6, 16'h5555, 1'b1, 3'd7, 16'hAAAA);
    chk("reset_wr_reg", 16'(bus.wr_reg), 16'h0);

    step(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
    chk("bypass_data", bus.wr_data, 16'h1234);
    idle();

    step(1'b0, 1'b1, 3'd2, 16'h0042, 1'b1, 3'd5, 16'hBEEF);
    chk("mem_first", bus.wr_data, 16'hBEEF);
    idle();
    chk("buffered_second", bus.wr_data, 16'h0042);
    idle();

    step(1'b0, 1'b1, 3'd1, 16'h0011, 1'b1, 3'd6, 16'hA000);
    step(1'b0, 1'b1, 3'd2, 16'h0022, 1'b1, 3'd6, 16'hA001);
    chk("stall_set", 16'(bus.alu_stall), 16'h1);
    step(1'b0, 1'b1, 3'd4, 16'h0044, 1'b1, 3'd6, 16'hA002);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'hA003);
    chk("full_hold", 16'(bus.alu_stall), 16'h1);
    idle();
    chk("drain_r1", bus.wr_data, 16'h0011);
    idle();
    chk("drain_r2", bus.wr_data, 16'h0022);
    idle();

    step(1'b0, 1'b1, 3'd1, 16'h0101, 1'b1, 3'd6, 16'hB000);
    step(1'b0, 1'b1, 3'd2, 16'h0202, 1'b1, 3'd6, 16'hB001);
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    chk("rst_flush_stall", 16'(bus.alu_stall), 16'h0);
    for (int i = 0; i < 4; i++) idle();

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 7),
           3'($urandom), 16'($urandom),
           ($urandom_range(0, 9) < 4),
           3'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
